// File: rtl/imem_loader_if.sv
// Boot-load link bundle between the host side (boot/debug link driver and
// instruction-memory / fetch consumers) and the imem_loader sequencer.
//
// Signals:
//   start, wordCount          load request and its word count
//   byteData/Valid/Ready      program byte stream, valid/ready handshake
//   memWriteEnable/Addr/Data  instruction-memory write port
//   cpuStall, busy, done,     CPU hold and loader status
//   error
//
// Modports:
//   master  host side: drives the request and byte stream, observes the rest
//   slave   loader side
interface imem_loader_if #(
  parameter int unsigned size   = 32,
  parameter int unsigned length = 256
);

  localparam int unsigned AW = $clog2(length);

  logic            start;
  logic [AW:0]     wordCount;
  logic [7:0]      byteData;
  logic            byteValid;
  logic            byteReady;
  logic            memWriteEnable;
  logic [AW-1:0]   memWriteAddr;
  logic [size-1:0] memWriteData;
  logic            cpuStall;
  logic            busy;
  logic            done;
  logic            error;

  modport master (
    output start,
    output wordCount,
    output byteData,
    output byteValid,
    input  byteReady,
    input  memWriteEnable,
    input  memWriteAddr,
    input  memWriteData,
    input  cpuStall,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  wordCount,
    input  byteData,
    input  byteValid,
    output byteReady,
    output memWriteEnable,
    output memWriteAddr,
    output memWriteData,
    output cpuStall,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory fill sequencer.
//
// Accepts a program as a byte stream, packs each group of size/8 bytes
// big-endian into one word, writes the words to consecutive instruction-memory
// addresses starting at 0, and keeps the CPU stalled until the requested
// number of words has been written.
//
// Ports:
//   clk     single clock, rising edge
//   resetN  synchronous, active-low reset
//   bus_io  imem_loader_if slave modport:
//             start/wordCount in    load request, count latched on start
//             byteData/Valid  in    program byte stream
//             byteReady       out   a byte transfers when valid && ready
//             memWrite*       out   one-cycle write strobe, address, data
//             cpuStall        out   1 = hold PC/fetch
//             busy/done/error out   status; error is sticky until next start
module imem_loader #(
  parameter int unsigned size   = 32,
  parameter int unsigned length = 256
) (
  input  logic         clk,
  input  logic         resetN,
  imem_loader_if.slave bus_io
);

  localparam int unsigned AW = $clog2(length);
  localparam int unsigned NB = size / 8;
  // Byte counter needs at least one bit even for single-byte words.
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [BW-1:0] LastByte = BW'(NB - 1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
  localparam logic [AW:0]   CntMax   = (AW + 1)'(length);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [size-1:0] shift_q, shift_d;
  // Last written address/data, so the write port holds steady between strobes.
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [size-1:0] wr_data_q, wr_data_d;
  logic            error_q, error_d;

  logic count_ok;
  logic byte_xfer;
  logic last_word;

  assign count_ok  = (bus_io.wordCount != '0) && (bus_io.wordCount <= CntMax);
  assign byte_xfer = bus_io.byteValid && (state_q == StLoad);
  // count_q >= 1 whenever a word is written, so count_q - 1 never underflows.
  assign last_word = ({1'b0, addr_q} == (count_q - CntOne));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    error_d    = error_q;

    unique case (state_q)
      // DONE accepts a new request exactly like IDLE.
      StIdle, StDone: begin
        if (bus_io.start) begin
          if (count_ok) begin
            count_d    = bus_io.wordCount;
            addr_d     = '0;
            byte_cnt_d = '0;
            error_d    = 1'b0;
            state_d    = StLoad;
          end else begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end
      end

      StLoad: begin
        if (byte_xfer) begin
          // Big-endian packing: earliest byte ends up in the top lane.
          shift_d = (shift_q << 8) | size'(bus_io.byteData);
          if (byte_cnt_q == LastByte) begin
            state_d = StWrite;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      StWrite: begin
        wr_addr_d = addr_q;
        wr_data_d = shift_q;
        if (last_word) begin
          state_d = StDone;
        end else begin
          addr_d     = addr_q + 1'b1;
          byte_cnt_d = '0;
          state_d    = StLoad;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= StIdle;
      count_q    <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    bus_io.byteReady      = (state_q == StLoad);
    bus_io.memWriteEnable = (state_q == StWrite);
    bus_io.memWriteAddr   = (state_q == StWrite) ? addr_q  : wr_addr_q;
    bus_io.memWriteData   = (state_q == StWrite) ? shift_q : wr_data_q;
    bus_io.cpuStall       = (state_q != StDone);
    bus_io.busy           = (state_q == StLoad) || (state_q == StWrite);
    bus_io.done           = (state_q == StDone);
    bus_io.error          = error_q;
  end

endmodule
